// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory slave controller.
package apb_mem_pkg;

  // Transfer FSM: waiting for a setup phase, or inside the access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Width of the wait-state counter (wait states range 0..15).
  localparam int CNT_WIDTH = 4;

  // Number of byte-offset bits inside one data word, log2(DATA_WIDTH/8).
  function automatic int byte_off_width(input int data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 0;
  endfunction

endpackage

// File: rtl/apb_mem_slave_ctrl_addr_check.sv
// Address window and alignment check: turns a byte address into a memory
// word index and flags addresses outside the window or not word aligned.
module apb_addr_check
  import apb_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  output logic [$clog2(MEM_WORDS)-1:0] word_index,
  output logic                         err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = byte_off_width(DATA_WIDTH);

  // One extra bit so the end of a window at the top of the address space does not wrap.
  localparam logic [ADDR_WIDTH:0]   WIN_END    = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_WORDS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  logic [ADDR_WIDTH-1:0] offset;

  // Word index is relative to the window base; error covers below, above and misaligned.
  always_comb begin
    offset     = addr - BASE_ADDR;
    word_index = IDX_W'(offset >> OFF_W);
    err        = (addr < BASE_ADDR) ||
                 ({1'b0, addr} >= WIN_END) ||
                 ((addr & ALIGN_MASK) != '0);
  end

endmodule

// File: rtl/apb_mem_slave_ctrl.sv
// APB slave terminating bridge transfers onto a single-port memory model,
// with programmable wait states, byte-strobe writes and PSLVERR on bad addresses.
module apb_mem_slave_ctrl
  import apb_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sel,
  input  logic                         enable,
  input  logic                         write,
  input  logic [DATA_WIDTH/8-1:0]      strobe,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic                         ready,
  output logic                         slverr,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         mem_wr,
  output logic                         mem_rd,
  output logic [DATA_WIDTH/8-1:0]      mem_be,
  output logic [$clog2(MEM_WORDS)-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]        mem_data_in,
  input  logic [DATA_WIDTH-1:0]        mem_data_out
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_WORDS);

  // Reads need at least one wait state because memory data arrives one cycle after mem_rd.
  localparam logic [CNT_WIDTH-1:0] RD_WAIT = CNT_WIDTH'((WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] WR_WAIT = CNT_WIDTH'(WAIT_CYCLES);

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   first_q;
  logic                   wr_q;
  logic                   err_q;
  logic [BYTES-1:0]       be_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [IDX_W-1:0]       chk_idx;
  logic                   chk_err;
  logic                   setup;

  apb_addr_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_check (
    .addr       (addr),
    .word_index (chk_idx),
    .err        (chk_err)
  );

  assign setup = (state == IDLE) && sel && !enable;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the setup phase, count down wait states and grab read data at the end of A0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      first_q <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      first_q <= 1'b0;
      if (setup) begin
        wr_q    <= write;
        err_q   <= chk_err;
        be_q    <= strobe;
        wdata_q <= wdata;
        idx_q   <= chk_idx;
        first_q <= 1'b1;
        if (chk_err)    cnt <= '0;
        else if (write) cnt <= WR_WAIT;
        else            cnt <= RD_WAIT;
      end else if (state == ACCESS) begin
        if (cnt != '0) cnt <= cnt - CNT_WIDTH'(1);
        if (first_q && !wr_q && !err_q) rdata_q <= mem_data_out;
      end
    end
  end

  // Next state and all outputs; everything is held at zero while reset is asserted.
  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    slverr      = 1'b0;
    rdata       = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_be      = '0;
    mem_address = '0;
    mem_data_in = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (sel && !enable) begin
            state_next  = ACCESS;
            mem_address = chk_idx;
            mem_rd      = !write && !chk_err;
          end
        end
        ACCESS: begin
          mem_be      = be_q;
          mem_address = idx_q;
          mem_data_in = wdata_q;
          if (!sel) begin
            state_next = IDLE;
          end else if (enable && (cnt == '0)) begin
            state_next = IDLE;
            ready      = 1'b1;
            slverr     = err_q;
            rdata      = (err_q || wr_q) ? '0 : rdata_q;
            mem_wr     = wr_q && (|be_q) && !err_q;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_ctrl.sv
// Self-checking bench for apb_mem_slave_ctrl: a table of directed transfers,
// multi-cycle abort/reset sequences, a zero-wait-state instance and random
// transfers checked against a word-level memory model.
module tb_apb_mem_slave_ctrl;

  // Transfer outcome observed on the DUT pins.
  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nwr;
    int          nrd;
    int          spurious;
    logic [7:0]  wr_idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [7:0]  rd_idx;
    logic        zeros;
  } xres_t;

  // Expected outcome of one transfer.
  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nwr;
    int          nrd;
    logic [7:0]  idx;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        sel          [2];
  logic        enable       [2];
  logic        write        [2];
  logic [3:0]  strobe       [2];
  logic [31:0] addr         [2];
  logic [31:0] wdata        [2];
  logic        ready        [2];
  logic        slverr       [2];
  logic [31:0] rdata        [2];
  logic        mem_wr       [2];
  logic        mem_rd       [2];
  logic [3:0]  mem_be       [2];
  logic [7:0]  mem_address  [2];
  logic [31:0] mem_data_in  [2];
  logic [31:0] mem_data_out [2];

  logic [31:0] bmem    [2][256];
  logic [31:0] ref_mem [2][256];

  int vectors;
  int miscompares;

  apb_mem_slave_ctrl #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .sel(sel[0]), .enable(enable[0]), .write(write[0]),
    .strobe(strobe[0]), .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]),
    .slverr(slverr[0]), .rdata(rdata[0]), .mem_wr(mem_wr[0]), .mem_rd(mem_rd[0]),
    .mem_be(mem_be[0]), .mem_address(mem_address[0]), .mem_data_in(mem_data_in[0]),
    .mem_data_out(mem_data_out[0])
  );

  apb_mem_slave_ctrl #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .sel(sel[1]), .enable(enable[1]), .write(write[1]),
    .strobe(strobe[1]), .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]),
    .slverr(slverr[1]), .rdata(rdata[1]), .mem_wr(mem_wr[1]), .mem_rd(mem_rd[1]),
    .mem_be(mem_be[1]), .mem_address(mem_address[1]), .mem_data_in(mem_data_in[1]),
    .mem_data_out(mem_data_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model behind each DUT: byte-enabled writes, read data one cycle after mem_rd.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wr[d])
        for (int b = 0; b < 4; b++)
          if (mem_be[d][b]) bmem[d][mem_address[d]][b*8 +: 8] <= mem_data_in[d][b*8 +: 8];
      if (mem_rd[d]) mem_data_out[d] <= bmem[d][mem_address[d]];
    end
  end

  // Safety net in case the bench itself gets stuck.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Word-level reference: window/alignment rules, latency rules and memory contents.
  function automatic exp_t modelExpect(input int d, input logic w, input logic [31:0] a,
                                       input logic [3:0] st, input int wait_cycles);
    exp_t e;
    e.err = (a < 32'h1000) || (a >= 32'h1400) || ((a % 4) != 0);
    e.idx = 8'((a - 32'h1000) / 4);
    e.lat = e.err ? 0 : (w ? wait_cycles : ((wait_cycles < 1) ? 1 : wait_cycles));
    e.rd  = (!e.err && !w) ? ref_mem[d][e.idx] : 32'h0;
    e.nwr = (!e.err && w && (st != 4'h0)) ? 1 : 0;
    e.nrd = (!e.err && !w) ? 1 : 0;
    return e;
  endfunction

  task automatic modelCommit(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    e = modelExpect(d, w, a, st, 0);
    if (!e.err && w)
      for (int b = 0; b < 4; b++)
        if (st[b]) ref_mem[d][e.idx][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  // One APB transfer; mode 1 drops sel and mode 2 pulses reset in access cycle stop_at.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] st,
                               input int stop_at, input int mode, output xres_t r);
    r.lat = -1; r.err = 1'b0; r.rd = '0; r.nwr = 0; r.nrd = 0; r.spurious = 0;
    r.wr_idx = '0; r.wr_be = '0; r.wr_data = '0; r.rd_idx = '0; r.zeros = 1'b0;
    @(negedge clk);
    sel[d] = 1'b1; enable[d] = 1'b0; write[d] = w; addr[d] = a; wdata[d] = wd; strobe[d] = st;
    #1;
    if (mem_rd[d]) begin r.nrd++; r.rd_idx = mem_address[d]; end
    if (mem_wr[d] || ready[d] || slverr[d] || (rdata[d] != 0)) r.spurious++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      enable[d] = 1'b1;
      if (k == stop_at && mode == 1) begin sel[d] = 1'b0; enable[d] = 1'b0; end
      if (k == stop_at && mode == 2) rst = 1'b1;
      #1;
      if (mem_rd[d]) r.nrd++;
      if (mem_wr[d]) begin
        r.nwr++; r.wr_idx = mem_address[d]; r.wr_be = mem_be[d]; r.wr_data = mem_data_in[d];
      end
      if (ready[d]) begin
        r.lat = k; r.err = slverr[d]; r.rd = rdata[d];
        break;
      end else if (slverr[d] || (rdata[d] != 0)) begin
        r.spurious++;
      end
      if (k == stop_at && mode != 0) begin
        @(negedge clk);
        rst = 1'b0; sel[d] = 1'b0; enable[d] = 1'b0;
        #1;
        if (mem_wr[d]) r.nwr++;
        r.zeros = !ready[d] && !slverr[d] && (rdata[d] == 0) && !mem_wr[d] && !mem_rd[d] &&
                  (mem_be[d] == 0) && (mem_address[d] == 0) && (mem_data_in[d] == 0);
        break;
      end
    end
  endtask

  task automatic idleCycle(input int d);
    @(negedge clk);
    sel[d] = 1'b0; enable[d] = 1'b0;
  endtask

  task automatic compareXfer(input string tag, input xres_t r, input exp_t e,
                             input logic [3:0] st, input logic [31:0] wd);
    checkOutput({tag, " ready_cycle"}, r.lat, e.lat);
    checkOutput({tag, " slverr"}, {31'b0, r.err}, {31'b0, e.err});
    checkOutput({tag, " rdata"}, r.rd, e.rd);
    checkOutput({tag, " mem_wr_count"}, r.nwr, e.nwr);
    checkOutput({tag, " mem_rd_count"}, r.nrd, e.nrd);
    checkOutput({tag, " stray_outputs"}, r.spurious, 0);
    if (e.nwr != 0) begin
      checkOutput({tag, " mem_address_wr"}, {24'b0, r.wr_idx}, {24'b0, e.idx});
      checkOutput({tag, " mem_be"}, {28'b0, r.wr_be}, {28'b0, st});
      checkOutput({tag, " mem_data_in"}, r.wr_data, wd);
    end
    if (e.nrd != 0) checkOutput({tag, " mem_address_rd"}, {24'b0, r.rd_idx}, {24'b0, e.idx});
  endtask

  // Model-checked transfer helper used by every non-table sequence.
  task automatic runChecked(input string tag, input int d, input int wait_cycles, input logic w,
                            input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    xres_t r;
    exp_t  e;
    e = modelExpect(d, w, a, st, wait_cycles);
    applyStimulus(d, w, a, wd, st, -1, 0, r);
    compareXfer(tag, r, e, st, wd);
    modelCommit(d, w, a, wd, st);
  endtask

  initial begin
    vec_t        tbl[$];
    xres_t       r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;

    vectors = 0;
    miscompares = 0;
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; enable[d] = 1'b0; write[d] = 1'b0; strobe[d] = '0;
      addr[d] = '0; wdata[d] = '0;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;
    end

    // Reset with a valid read setup presented: every output must stay at zero.
    rst = 1'b1;
    sel[0] = 1'b1; addr[0] = 32'h1004;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset mem_rd", {31'b0, mem_rd[0]}, 32'h0);
    checkOutput("reset mem_address", {24'b0, mem_address[0]}, 32'h0);
    checkOutput("reset ready", {31'b0, ready[0]}, 32'h0);
    checkOutput("reset slverr", {31'b0, slverr[0]}, 32'h0);
    checkOutput("reset rdata", rdata[0], 32'h0);
    checkOutput("reset mem_wr", {31'b0, mem_wr[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0; sel[0] = 1'b0;

    // Directed table, applied back to back with no idle cycle between entries.
    tbl.push_back('{1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, '{2, 1'b0, 32'h0,        1, 0, 8'd1}});
    tbl.push_back('{1'b0, 32'h1004, 32'h0,        4'h0, '{2, 1'b0, 32'hDEADBEEF, 0, 1, 8'd1}});
    tbl.push_back('{1'b1, 32'h1008, 32'h11223344, 4'hF, '{2, 1'b0, 32'h0,        1, 0, 8'd2}});
    tbl.push_back('{1'b1, 32'h1008, 32'h0000AB00, 4'h2, '{2, 1'b0, 32'h0,        1, 0, 8'd2}});
    tbl.push_back('{1'b0, 32'h1008, 32'h0,        4'h0, '{2, 1'b0, 32'h1122AB44, 0, 1, 8'd2}});
    tbl.push_back('{1'b1, 32'h1008, 32'hFFFFFFFF, 4'h0, '{2, 1'b0, 32'h0,        0, 0, 8'd2}});
    tbl.push_back('{1'b0, 32'h1008, 32'h0,        4'h0, '{2, 1'b0, 32'h1122AB44, 0, 1, 8'd2}});
    tbl.push_back('{1'b0, 32'h0FFC, 32'h0,        4'h0, '{0, 1'b1, 32'h0,        0, 0, 8'd0}});
    tbl.push_back('{1'b0, 32'h1400, 32'h0,        4'h0, '{0, 1'b1, 32'h0,        0, 0, 8'd0}});
    tbl.push_back('{1'b1, 32'h1002, 32'h12345678, 4'hF, '{0, 1'b1, 32'h0,        0, 0, 8'd0}});
    tbl.push_back('{1'b1, 32'h13FC, 32'hCAFEF00D, 4'hF, '{2, 1'b0, 32'h0,        1, 0, 8'd255}});
    tbl.push_back('{1'b0, 32'h13FC, 32'h0,        4'h0, '{2, 1'b0, 32'hCAFEF00D, 0, 1, 8'd255}});
    tbl.push_back('{1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, '{2, 1'b0, 32'h0,        1, 0, 8'd0}});
    tbl.push_back('{1'b0, 32'h1000, 32'h0,        4'h0, '{2, 1'b0, 32'hA5A5A5A5, 0, 1, 8'd0}});
    tbl.push_back('{1'b0, 32'h1001, 32'h0,        4'h0, '{0, 1'b1, 32'h0,        0, 0, 8'd0}});
    foreach (tbl[i]) begin
      applyStimulus(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].st, -1, 0, r);
      compareXfer($sformatf("table[%0d]", i), r, tbl[i].e, tbl[i].st, tbl[i].wd);
      modelCommit(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].st);
    end
    idleCycle(0);

    // Give the words used by the random phase known contents.
    for (int i = 0; i < 16; i++) runChecked($sformatf("init[%0d]", i), 0, 2, 1'b1, 32'h1000 + 32'(4*i), $urandom, 4'hF);
    idleCycle(0);

    // sel dropped in A1 of a write: no memory write, and the next transfer sees an idle FSM.
    runChecked("pre_abort write", 0, 2, 1'b1, 32'h1020, 32'h11111111, 4'hF);
    applyStimulus(0, 1'b1, 32'h1020, 32'h22222222, 4'hF, 1, 1, r);
    checkOutput("abort mem_wr_count", r.nwr, 0);
    checkOutput("abort ready_cycle", r.lat, -1);
    checkOutput("abort outputs_zero", {31'b0, r.zeros}, 32'h1);
    runChecked("post_abort read", 0, 2, 1'b0, 32'h1020, 32'h0, 4'h0);

    // Reset in A1 of a write: transfer discarded, outputs zero next cycle, then normal operation.
    runChecked("pre_reset write", 0, 2, 1'b1, 32'h1024, 32'h33333333, 4'hF);
    applyStimulus(0, 1'b1, 32'h1024, 32'h44444444, 4'hF, 1, 2, r);
    checkOutput("reset_mid mem_wr_count", r.nwr, 0);
    checkOutput("reset_mid outputs_zero", {31'b0, r.zeros}, 32'h1);
    runChecked("post_reset read", 0, 2, 1'b0, 32'h1024, 32'h0, 4'h0);
    runChecked("post_reset write", 0, 2, 1'b1, 32'h1024, 32'h55667788, 4'h5);
    runChecked("post_reset readback", 0, 2, 1'b0, 32'h1024, 32'h0, 4'h0);
    idleCycle(0);

    // Zero-wait-state instance: write in A0, read in A1, error in A0.
    runChecked("w0 write", 1, 0, 1'b1, 32'h1010, 32'h5A5A5A5A, 4'hF);
    runChecked("w0 read", 1, 0, 1'b0, 32'h1010, 32'h0, 4'h0);
    runChecked("w0 err read", 1, 0, 1'b0, 32'h0FFC, 32'h0, 4'h0);
    runChecked("w0 zero strobe", 1, 0, 1'b1, 32'h1010, 32'hFFFFFFFF, 4'h0);
    runChecked("w0 readback", 1, 0, 1'b0, 32'h1010, 32'h0, 4'h0);
    idleCycle(1);

    // Random transfers against the reference memory.
    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0:       a = 32'h0FFC - 32'(4 * $urandom_range(0, 3));
        1:       a = 32'h1400 + 32'(4 * $urandom_range(0, 3));
        2:       a = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        3:       a = 32'h13FC;
        default: a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      endcase
      runChecked($sformatf("rand[%0d]", n), 0, 2, w, a, wd, st);
      if ($urandom_range(0, 1) == 1) idleCycle(0);
    end
    idleCycle(0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
